// File: rtl/mips_pkg.sv
// mips_pkg: definitions shared by the multicycle MIPS fetch path.
//   RESET_PC_DEF    - default PC value after reset
//   TIMEOUT_CYC_DEF - default number of WAIT cycles before a fetch is abandoned
//   NOP_INSN        - instruction loaded into IR when a fetch times out
//   fetch_state_e   - fetch FSM state encoding
//   pc_add4         - sequential-PC helper; wraps modulo 2^32
package mips_pkg;

  localparam logic [31:0] RESET_PC_DEF    = 32'h0000_3000;
  localparam int unsigned TIMEOUT_CYC_DEF = 255;
  localparam logic [31:0] NOP_INSN        = 32'h0000_0000;

  typedef enum logic [1:0] {
    FS_IDLE = 2'd0,
    FS_REQ  = 2'd1,
    FS_WAIT = 2'd2
  } fetch_state_e;

  function automatic logic [31:0] pc_add4(input logic [31:0] pc_val);
    return pc_val + 32'd4;
  endfunction

endpackage

// File: rtl/pc_fetch_unit_if.sv
// pc_fetch_unit_if: instruction-memory request/response bus.
//   imem_req    - request valid (fetch unit -> memory)
//   imem_addr   - request address, held while imem_req is high
//   imem_gnt    - memory accepted the request
//   imem_rvalid - read data valid
//   imem_rdata  - read data
// Modports: master (fetch unit side), slave (memory side).
interface pc_fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_gnt,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_gnt,
    output imem_rvalid,
    output imem_rdata
  );
endinterface

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: architectural PC and instruction fetch for the multicycle MIPS core.
// Holds the PC, fetches the word at PC over the imem req/gnt/rvalid bus into the IR,
// and returns pc / pc+4 to the next-PC logic.
//
// Ports:
//   clk, rst_n    - clock; synchronous active-low reset
//   npc           - next PC from the next-PC logic
//   pc_write      - load npc into PC (deferred to fetch completion while busy)
//   fetch_start   - start a fetch at the current PC (ignored while busy)
//   pc, pcplus4   - current PC and PC+4 (combinational, wraps)
//   imem          - instruction memory bus (master modport)
//   ir, ir_valid  - instruction register and its valid flag
//   fetch_busy    - high in REQ or WAIT
//   fetch_err     - sticky: last fetch timed out (cleared by next fetch_start)
//   misalign_err  - one-cycle pulse for a rejected misaligned npc
//
// Build option: define PC_ALIGN_CHECK_EN to reject misaligned npc values and pulse
// misalign_err; otherwise npc[1:0] is forced to 00 and misalign_err stays 0.
module pc_fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = RESET_PC_DEF,
  parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [31:0]            npc,
  input  logic                   pc_write,
  input  logic                   fetch_start,
  output logic [31:0]            pc,
  output logic [31:0]            pcplus4,
  pc_fetch_unit_if.master        imem,
  output logic [31:0]            ir,
  output logic                   ir_valid,
  output logic                   fetch_busy,
  output logic                   fetch_err,
  output logic                   misalign_err
);

  localparam logic [15:0] TMO_LIMIT = 16'(TIMEOUT_CYC);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  ir_q, ir_d;
  logic         ir_valid_q, ir_valid_d;
  logic         req_q, req_d;
  logic [31:0]  addr_q, addr_d;
  logic         ferr_q, ferr_d;
  logic         pend_vld_q, pend_vld_d;
  logic [31:0]  pend_pc_q, pend_pc_d;
  logic [15:0]  cnt_q, cnt_d;
  logic         misalign_q, misalign_d;

  logic [15:0]  cnt_inc;
  logic         fetch_done;   // this edge returns the FSM to IDLE
  logic         wr_ok;        // pc_write accepted this cycle
  logic [31:0]  npc_ld;       // value loaded into PC / pending register
  logic         misalign_set;

`ifdef PC_ALIGN_CHECK_EN
  assign wr_ok        = pc_write & (npc[1:0] == 2'b00);
  assign npc_ld       = npc;
  assign misalign_set = pc_write & (npc[1:0] != 2'b00);
`else
  assign wr_ok        = pc_write;
  assign npc_ld       = npc & 32'hFFFF_FFFC;
  assign misalign_set = 1'b0;
`endif

  assign cnt_inc = cnt_q + 16'd1;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ir_d        = ir_q;
    ir_valid_d  = ir_valid_q;
    req_d       = req_q;
    addr_d      = addr_q;
    ferr_d      = ferr_q;
    pend_vld_d  = pend_vld_q;
    pend_pc_d   = pend_pc_q;
    cnt_d       = cnt_q;
    misalign_d  = misalign_set;
    fetch_done  = 1'b0;

    unique case (state_q)
      FS_IDLE: begin
        if (fetch_start) begin
          // Address uses the PC before any same-cycle pc_write.
          addr_d     = pc_q;
          req_d      = 1'b1;
          ir_valid_d = 1'b0;
          ferr_d     = 1'b0;
          state_d    = FS_REQ;
        end
      end
      FS_REQ: begin
        if (imem.imem_gnt) begin
          req_d = 1'b0;
          if (imem.imem_rvalid) begin
            // Zero-latency memory: data arrives with the grant.
            ir_d       = imem.imem_rdata;
            ir_valid_d = 1'b1;
            state_d    = FS_IDLE;
            fetch_done = 1'b1;
          end else begin
            cnt_d   = 16'd0;
            state_d = FS_WAIT;
          end
        end
      end
      FS_WAIT: begin
        if (imem.imem_rvalid) begin
          ir_d       = imem.imem_rdata;
          ir_valid_d = 1'b1;
          state_d    = FS_IDLE;
          fetch_done = 1'b1;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == TMO_LIMIT) begin
            // Abandon the fetch; decode sees a NOP and fetch_err flags it.
            ir_d       = NOP_INSN;
            ir_valid_d = 1'b1;
            ferr_d     = 1'b1;
            state_d    = FS_IDLE;
            fetch_done = 1'b1;
          end
        end
      end
      default: begin
        state_d = FS_IDLE;
      end
    endcase

    // PC loads directly when idle; while busy they are parked and applied on the
    // edge that returns to IDLE, with a write on that same edge taking priority.
    if (state_q == FS_IDLE) begin
      if (wr_ok) begin
        pc_d = npc_ld;
      end
    end else begin
      if (wr_ok) begin
        pend_pc_d  = npc_ld;
        pend_vld_d = 1'b1;
      end
      if (fetch_done) begin
        pend_vld_d = 1'b0;
        if (wr_ok) begin
          pc_d = npc_ld;
        end else if (pend_vld_q) begin
          pc_d = pend_pc_q;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= FS_IDLE;
      pc_q       <= RESET_PC;
      ir_q       <= 32'h0000_0000;
      ir_valid_q <= 1'b0;
      req_q      <= 1'b0;
      addr_q     <= 32'h0000_0000;
      ferr_q     <= 1'b0;
      pend_vld_q <= 1'b0;
      cnt_q      <= 16'd0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      ir_valid_q <= ir_valid_d;
      req_q      <= req_d;
      addr_q     <= addr_d;
      ferr_q     <= ferr_d;
      pend_vld_q <= pend_vld_d;
      cnt_q      <= cnt_d;
      misalign_q <= misalign_d;
    end
  end

  // Pending value is qualified by pend_vld_q, so it needs no reset.
  always_ff @(posedge clk) begin
    pend_pc_q <= pend_pc_d;
  end

  assign pc             = pc_q;
  assign pcplus4        = pc_add4(pc_q);
  assign imem.imem_req  = req_q;
  assign imem.imem_addr = addr_q;
  assign ir             = ir_q;
  assign ir_valid       = ir_valid_q;
  assign fetch_busy     = (state_q != FS_IDLE);
  assign fetch_err      = ferr_q;
  assign misalign_err   = misalign_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit: directed, table-driven bench for pc_fetch_unit plus hand-written
// sequences for timeout and reset during an outstanding fetch.
module tb_pc_fetch_unit;
  import mips_pkg::*;

`ifdef PC_ALIGN_CHECK_EN
  localparam bit ALIGN_CHK = 1'b1;
`else
  localparam bit ALIGN_CHK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] npc;
  logic        pc_write;
  logic        fetch_start;
  logic [31:0] pc, pcplus4, ir;
  logic        ir_valid, fetch_busy, fetch_err, misalign_err;

  pc_fetch_unit_if bus();

  pc_fetch_unit #(
    .RESET_PC    (32'h0000_3000),
    .TIMEOUT_CYC (255)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .npc          (npc),
    .pc_write     (pc_write),
    .fetch_start  (fetch_start),
    .pc           (pc),
    .pcplus4      (pcplus4),
    .imem         (bus),
    .ir           (ir),
    .ir_valid     (ir_valid),
    .fetch_busy   (fetch_busy),
    .fetch_err    (fetch_err),
    .misalign_err (misalign_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic        rst_n, fs, pw;
    logic [31:0] npc;
    logic        gnt, rv;
    logic [31:0] rdata;
    logic [31:0] pc, ir;
    logic        irv, req;
    logic [31:0] addr;
    logic        busy, ferr, merr;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(input logic r, fs, pw, input logic [31:0] n,
                              input logic g, rv, input logic [31:0] rd,
                              input logic [31:0] epc, eir, input logic eirv, ereq,
                              input logic [31:0] eaddr, input logic ebusy, eferr, emerr);
    vec_t v;
    v.rst_n = r; v.fs = fs; v.pw = pw; v.npc = n; v.gnt = g; v.rv = rv; v.rdata = rd;
    v.pc = epc; v.ir = eir; v.irv = eirv; v.req = ereq; v.addr = eaddr;
    v.busy = ebusy; v.ferr = eferr; v.merr = emerr;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, fs, pw, input logic [31:0] n,
                       input logic g, rv, input logic [31:0] rd);
    rst_n = r; fetch_start = fs; pc_write = pw; npc = n;
    bus.imem_gnt = g; bus.imem_rvalid = rv; bus.imem_rdata = rd;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] pcm;
    pcm = ALIGN_CHK ? 32'h0000_3400 : 32'h0000_3404;

    //          rst fs pw npc           g  rv rdata          pc            ir            irv req addr          bsy fe me
    vt.push_back(mk(0, 0, 0, 32'h0,         0, 0, 32'h0,         32'h00003000, 32'h0,        0, 0, 32'h0,        0, 0, 0));
    vt.push_back(mk(1, 0, 0, 32'h0,         0, 0, 32'h0,         32'h00003000, 32'h0,        0, 0, 32'h0,        0, 0, 0));
    // zero-latency fetch
    vt.push_back(mk(1, 1, 0, 32'h0,         0, 0, 32'h0,         32'h00003000, 32'h0,        0, 1, 32'h00003000, 1, 0, 0));
    vt.push_back(mk(1, 0, 0, 32'h0,         1, 1, 32'h8C080004,  32'h00003000, 32'h8C080004, 1, 0, 32'h00003000, 0, 0, 0));
    // late grant, stray rvalid in REQ ignored, data two cycles after grant
    vt.push_back(mk(1, 1, 0, 32'h0,         0, 0, 32'h0,         32'h00003000, 32'h8C080004, 0, 1, 32'h00003000, 1, 0, 0));
    vt.push_back(mk(1, 0, 0, 32'h0,         0, 1, 32'hDEAD0000,  32'h00003000, 32'h8C080004, 0, 1, 32'h00003000, 1, 0, 0));
    vt.push_back(mk(1, 1, 0, 32'h0,         0, 0, 32'h0,         32'h00003000, 32'h8C080004, 0, 1, 32'h00003000, 1, 0, 0));
    vt.push_back(mk(1, 0, 0, 32'h0,         1, 0, 32'h0,         32'h00003000, 32'h8C080004, 0, 0, 32'h00003000, 1, 0, 0));
    vt.push_back(mk(1, 0, 0, 32'h0,         0, 0, 32'h0,         32'h00003000, 32'h8C080004, 0, 0, 32'h00003000, 1, 0, 0));
    vt.push_back(mk(1, 0, 0, 32'h0,         0, 1, 32'h24080001,  32'h00003000, 32'h24080001, 1, 0, 32'h00003000, 0, 0, 0));
    // deferred pc_write in WAIT
    vt.push_back(mk(1, 1, 0, 32'h0,         0, 0, 32'h0,         32'h00003000, 32'h24080001, 0, 1, 32'h00003000, 1, 0, 0));
    vt.push_back(mk(1, 0, 0, 32'h0,         1, 0, 32'h0,         32'h00003000, 32'h24080001, 0, 0, 32'h00003000, 1, 0, 0));
    vt.push_back(mk(1, 0, 1, 32'h00003040,  0, 0, 32'h0,         32'h00003000, 32'h24080001, 0, 0, 32'h00003000, 1, 0, 0));
    vt.push_back(mk(1, 0, 0, 32'h0,         0, 0, 32'h0,         32'h00003000, 32'h24080001, 0, 0, 32'h00003000, 1, 0, 0));
    vt.push_back(mk(1, 0, 0, 32'h0,         0, 1, 32'h11111111,  32'h00003040, 32'h11111111, 1, 0, 32'h00003000, 0, 0, 0));
    // two pending writes, latest wins
    vt.push_back(mk(1, 1, 0, 32'h0,         0, 0, 32'h0,         32'h00003040, 32'h11111111, 0, 1, 32'h00003040, 1, 0, 0));
    vt.push_back(mk(1, 0, 1, 32'h00003100,  0, 0, 32'h0,         32'h00003040, 32'h11111111, 0, 1, 32'h00003040, 1, 0, 0));
    vt.push_back(mk(1, 0, 0, 32'h0,         1, 0, 32'h0,         32'h00003040, 32'h11111111, 0, 0, 32'h00003040, 1, 0, 0));
    vt.push_back(mk(1, 0, 1, 32'h00003080,  0, 0, 32'h0,         32'h00003040, 32'h11111111, 0, 0, 32'h00003040, 1, 0, 0));
    vt.push_back(mk(1, 0, 0, 32'h0,         0, 1, 32'h22222222,  32'h00003080, 32'h22222222, 1, 0, 32'h00003040, 0, 0, 0));
    // write on the IDLE-return edge beats the pending value
    vt.push_back(mk(1, 1, 0, 32'h0,         0, 0, 32'h0,         32'h00003080, 32'h22222222, 0, 1, 32'h00003080, 1, 0, 0));
    vt.push_back(mk(1, 0, 0, 32'h0,         1, 0, 32'h0,         32'h00003080, 32'h22222222, 0, 0, 32'h00003080, 1, 0, 0));
    vt.push_back(mk(1, 0, 1, 32'h00003200,  0, 0, 32'h0,         32'h00003080, 32'h22222222, 0, 0, 32'h00003080, 1, 0, 0));
    vt.push_back(mk(1, 0, 1, 32'h00003300,  0, 1, 32'h33333333,  32'h00003300, 32'h33333333, 1, 0, 32'h00003080, 0, 0, 0));
    // fetch_start + pc_write together in IDLE: fetch uses old pc
    vt.push_back(mk(1, 1, 1, 32'h00003400,  0, 0, 32'h0,         32'h00003400, 32'h33333333, 0, 1, 32'h00003300, 1, 0, 0));
    vt.push_back(mk(1, 0, 0, 32'h0,         1, 1, 32'h44444444,  32'h00003400, 32'h44444444, 1, 0, 32'h00003300, 0, 0, 0));
    // misaligned npc
    vt.push_back(mk(1, 0, 1, 32'h00003406,  0, 0, 32'h0,         pcm,          32'h44444444, 1, 0, 32'h00003300, 0, 0, ALIGN_CHK));
    vt.push_back(mk(1, 0, 0, 32'h0,         0, 0, 32'h0,         pcm,          32'h44444444, 1, 0, 32'h00003300, 0, 0, 0));
    // pcplus4 wrap
    vt.push_back(mk(1, 0, 1, 32'hFFFFFFFC,  0, 0, 32'h0,         32'hFFFFFFFC, 32'h44444444, 1, 0, 32'h00003300, 0, 0, 0));
    vt.push_back(mk(1, 0, 1, 32'h00003000,  0, 0, 32'h0,         32'h00003000, 32'h44444444, 1, 0, 32'h00003300, 0, 0, 0));

    foreach (vt[i]) begin
      drive(vt[i].rst_n, vt[i].fs, vt[i].pw, vt[i].npc, vt[i].gnt, vt[i].rv, vt[i].rdata);
      tick();
      chk($sformatf("v%0d.pc", i),       pc,                 vt[i].pc);
      chk($sformatf("v%0d.pcplus4", i),  pcplus4,            vt[i].pc + 32'd4);
      chk($sformatf("v%0d.ir", i),       ir,                 vt[i].ir);
      chk($sformatf("v%0d.ir_valid", i), {31'b0, ir_valid},  {31'b0, vt[i].irv});
      chk($sformatf("v%0d.req", i),      {31'b0, bus.imem_req}, {31'b0, vt[i].req});
      chk($sformatf("v%0d.addr", i),     bus.imem_addr,      vt[i].addr);
      chk($sformatf("v%0d.busy", i),     {31'b0, fetch_busy}, {31'b0, vt[i].busy});
      chk($sformatf("v%0d.ferr", i),     {31'b0, fetch_err},  {31'b0, vt[i].ferr});
      chk($sformatf("v%0d.merr", i),     {31'b0, misalign_err}, {31'b0, vt[i].merr});
    end

    // Timeout: 255 WAIT cycles without rvalid
    drive(1, 1, 0, 32'h0, 0, 0, 32'h0); tick();
    drive(1, 0, 0, 32'h0, 1, 0, 32'h0); tick();
    chk("tmo.enter_wait_req", {31'b0, bus.imem_req}, 32'd0);
    drive(1, 0, 0, 32'h0, 0, 0, 32'h0);
    for (int k = 0; k < 254; k++) tick();
    chk("tmo.busy_254", {31'b0, fetch_busy}, 32'd1);
    chk("tmo.irv_254",  {31'b0, ir_valid},   32'd0);
    tick();
    chk("tmo.ir",   ir,                      NOP_INSN);
    chk("tmo.irv",  {31'b0, ir_valid},       32'd1);
    chk("tmo.ferr", {31'b0, fetch_err},      32'd1);
    chk("tmo.busy", {31'b0, fetch_busy},     32'd0);
    tick();
    chk("tmo.ferr_sticky", {31'b0, fetch_err}, 32'd1);

    // next fetch clears fetch_err, then completes normally
    drive(1, 1, 0, 32'h0, 0, 0, 32'h0); tick();
    chk("clr.ferr", {31'b0, fetch_err}, 32'd0);
    chk("clr.irv",  {31'b0, ir_valid},  32'd0);
    drive(1, 0, 0, 32'h0, 1, 1, 32'h55555555); tick();
    chk("clr.ir", ir, 32'h55555555);

    // Reset during WAIT, then a stray rvalid
    drive(1, 0, 1, 32'h00003010, 0, 0, 32'h0); tick();
    chk("rst.pc_pre", pc, 32'h00003010);
    drive(1, 1, 0, 32'h0, 0, 0, 32'h0); tick();
    drive(1, 0, 0, 32'h0, 1, 0, 32'h0); tick();
    drive(1, 0, 0, 32'h0, 0, 0, 32'h0); tick();
    chk("rst.busy_pre", {31'b0, fetch_busy}, 32'd1);
    drive(0, 0, 0, 32'h0, 0, 0, 32'h0); tick();
    chk("rst.pc",   pc,                  32'h00003000);
    chk("rst.ir",   ir,                  32'h0);
    chk("rst.irv",  {31'b0, ir_valid},   32'd0);
    chk("rst.busy", {31'b0, fetch_busy}, 32'd0);
    chk("rst.addr", bus.imem_addr,       32'h0);
    drive(1, 0, 0, 32'h0, 0, 1, 32'hDEADBEEF); tick();
    chk("stray.ir",   ir,                  32'h0);
    chk("stray.irv",  {31'b0, ir_valid},   32'd0);
    chk("stray.busy", {31'b0, fetch_busy}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Holds the architectural PC for the multicycle MIPS core and consumes the next-PC value (npc) chosen by the next-PC logic.
- Fetches the instruction at PC from instruction memory over a req/gnt/rvalid handshake and latches it into the instruction register (IR) for decode.
- Supplies pc and pc+4 back to the next-PC logic, closing the PC loop.

Parameters:
- RESET_PC, 32'h0000_3000, PC value after reset.
- TIMEOUT_CYC, 255, WAIT-state cycles before a fetch is aborted with fetch_err (1..65535).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  reset; one clock; reset is synchronous and active-low.
- npc  in  32  next PC from next-PC logic.
- pc_write  in  1  control strobe: load npc into PC.
- fetch_start  in  1  control strobe: fetch instruction at current PC.
- pc  out  32  current PC.
- pcplus4  out  32  pc + 4, combinational, wraps mod 2^32.
- imem_req  out  1  instruction memory request.
- imem_addr  out  32  request address; stable while imem_req=1.
- imem_gnt  in  1  memory accepted request.
- imem_rvalid  in  1  read data valid.
- imem_rdata  in  32  read data.
- ir  out  32  instruction register.
- ir_valid  out  1  ir holds result of last fetch.
- fetch_busy  out  1  1 in REQ or WAIT.
- fetch_err  out  1  sticky: last fetch timed out.
- misalign_err  out  1  one-cycle pulse, rejected misaligned npc (see Optional Feature).

Behaviour:
- Reset (rst_n=0 at edge): pc=RESET_PC, ir=0, ir_valid=0, imem_req=0, imem_addr=0, fetch_err=0, misalign_err=0, pending write cleared, timeout counter 0, state IDLE. Reset mid-fetch abandons the transaction; late rvalid after reset is ignored.
- States: IDLE, REQ, WAIT.
- IDLE, fetch_start=1: imem_addr<=pc (value before any same-cycle pc_write), imem_req<=1, ir_valid<=0, fetch_err<=0, go REQ.
- REQ: imem_req and imem_addr held until imem_gnt=1.
  - gnt with rvalid=0: imem_req<=0, counter<=0, go WAIT.
  - gnt and rvalid in the same cycle (zero-latency memory): ir<=rdata, ir_valid<=1, imem_req<=0, go IDLE.
  - REQ has no timeout.
- WAIT:
  - rvalid=1: ir<=rdata, ir_valid<=1, go IDLE.
  - Otherwise counter increments. On reaching TIMEOUT_CYC: ir<=32'h0000_0000 (NOP), ir_valid<=1, fetch_err<=1, go IDLE.
  - rvalid outside WAIT/REQ-with-gnt is ignored.
- Fetch latency: 2 cycles from fetch_start to ir_valid with zero-wait gnt+rvalid; each extra wait cycle adds 1.
- fetch_start while fetch_busy=1 is ignored.
- pc_write in IDLE: pc<=npc at that edge.
  - Simultaneous fetch_start: fetch uses old pc, and pc takes npc.
- pc_write in REQ/WAIT: npc captured into a pending register (latest write wins) and applied on the edge that returns to IDLE. imem_addr is never disturbed.
- pc_write and the IDLE-return edge coincide: the new pc_write value wins.
- pcplus4: 32'hFFFF_FFFC -> 32'h0000_0000.

Optional Feature:
- Macro PC_ALIGN_CHECK_EN.
- Defined: pc_write with npc[1:0]!=0 leaves pc (and pending) unchanged and pulses misalign_err for 1 cycle. The pulse happens at acceptance time, including deferred writes.
- Undefined: npc[1:0] forced to 2'b00 on load; misalign_err tied 0.

Decomposition:
- Shared package (mips_pkg): RESET_PC default, NOP encoding 32'h0000_0000, fetch FSM state encoding, TIMEOUT_CYC default.
- No sub-module; the timeout counter is inline (a separate module adds nothing).

Test Plan:
- Reset release -> pc=0x00003000, pcplus4=0x00003004, ir_valid=0, imem_req=0; fetch_start with gnt+rvalid same cycle, rdata=0x8C080004 -> imem_addr=0x00003000, ir=0x8C080004, ir_valid=1 two cycles after start.
- Fetch with gnt after 3 cycles, rvalid 2 cycles later -> imem_addr stable throughout REQ, ir_valid=1 exactly one cycle after rvalid, fetch_busy high in between.
- pc_write npc=0x00003040 in WAIT, then rvalid -> pc stays 0x00003000 until the IDLE-return edge, then 0x00003040; second pc_write 0x00003080 while pending -> final pc=0x00003080.
- No rvalid for TIMEOUT_CYC=255 cycles in WAIT -> ir=0x00000000, ir_valid=1, fetch_err=1; next fetch_start clears fetch_err.
- rst_n=0 during WAIT, then stray rvalid -> state IDLE, ir=0, ir_valid=0, pc=0x00003000.
- pc_write npc=0x00003006: with PC_ALIGN_CHECK_EN -> pc unchanged, misalign_err pulse 1 cycle; without -> pc=0x00003004, misalign_err=0.
